mbist_march_ctrl: RTL and testbench

Memory built-in self-test controller that drives a `fault_mem`-style single-port memory through the March C- algorithm and reports pass/fail with diagnostics.
- Owns the memory's `write_read`/`address`/`wdata` pins during a test.
- Compensates for the memory's one-cycle write-data register and two-cycle read latency.
- Compares every read against the expected background and counts mismatches.
- Sits between the chip-level test access logic (start/status) and one memory instance.

---
 rtl/mbist_pkg.sv | 37 +++
 rtl/mbist_cmp_pipe.sv | 84 ++++++++
 rtl/mbist_march_ctrl.sv | 156 +++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST controller.
package mbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef logic [2:0] elem_t;

  localparam elem_t LAST_ELEM = 3'd5;

  typedef struct packed {
    logic dir_down;   // 1 = walk addresses high to low
    logic has_read;
    logic has_write;
    logic rd_bg;      // expected background of the read op
    logic wr_bg;      // background written by the write op
  } elem_cfg_t;

  // E0 up w0 | E1 up r0,w1 | E2 up r1,w0 | E3 down r0,w1 | E4 down r1,w0 | E5 up r0
  function automatic elem_cfg_t elem_cfg(input elem_t e);
    case (e)
      3'd0:    return '{dir_down: 1'b0, has_read: 1'b0, has_write: 1'b1, rd_bg: 1'b0, wr_bg: 1'b0};
      3'd1:    return '{dir_down: 1'b0, has_read: 1'b1, has_write: 1'b1, rd_bg: 1'b0, wr_bg: 1'b1};
      3'd2:    return '{dir_down: 1'b0, has_read: 1'b1, has_write: 1'b1, rd_bg: 1'b1, wr_bg: 1'b0};
      3'd3:    return '{dir_down: 1'b1, has_read: 1'b1, has_write: 1'b1, rd_bg: 1'b0, wr_bg: 1'b1};
      3'd4:    return '{dir_down: 1'b1, has_read: 1'b1, has_write: 1'b1, rd_bg: 1'b1, wr_bg: 1'b0};
      3'd5:    return '{dir_down: 1'b0, has_read: 1'b1, has_write: 1'b0, rd_bg: 1'b0, wr_bg: 1'b0};
      default: return '{dir_down: 1'b0, has_read: 1'b0, has_write: 1'b0, rd_bg: 1'b0, wr_bg: 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// Two-stage read-compare pipeline matching the memory's read latency, with a
// saturating mismatch counter. MBIST_DIAG_EN adds first-failure address/syndrome.
module mbist_cmp_pipe
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  issue_valid,
  input  logic                  issue_bg,
`ifdef MBIST_DIAG_EN
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
`endif
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [CNT_WIDTH-1:0]  fail_count
);

  logic                  v1_q, v2_q;
  logic                  bg1_q, bg2_q;
  logic [DATA_WIDTH-1:0] syndrome;
  logic                  mismatch;

  assign syndrome = rdata ^ {DATA_WIDTH{bg2_q}};
  assign mismatch = v2_q && (syndrome != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      bg1_q <= 1'b0;
      bg2_q <= 1'b0;
    end else begin
      v1_q  <= issue_valid;
      v2_q  <= v1_q;
      bg1_q <= issue_bg;
      bg2_q <= bg1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_count <= '0;
    end else if (clear) begin
      fail_count <= '0;
    end else if (mismatch && (fail_count != '1)) begin
      fail_count <= fail_count + CNT_WIDTH'(1);
    end
  end

`ifdef MBIST_DIAG_EN
  logic [ADDR_WIDTH-1:0] a1_q, a2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q <= '0;
      a2_q <= '0;
    end else begin
      a1_q <= issue_addr;
      a2_q <= a1_q;
    end
  end

  // A zero count means no earlier mismatch in this test, so this one is the first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_addr <= '0;
      fail_data <= '0;
    end else if (clear) begin
      fail_addr <= '0;
      fail_data <= '0;
    end else if (mismatch && (fail_count == '0)) begin
      fail_addr <= a2_q;
      fail_data <= syndrome;
    end
  end
`endif

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller for a single-port memory with registered wdata and
// 2-cycle read latency. Optional diagnostics: define MBIST_DIAG_EN.
// Memory handshake: one op per cycle, no back-pressure; write_read=1 writes the
// previous cycle's mem_wdata, a read returns mem_rdata two cycles after issue.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  fail_count,
`ifdef MBIST_DIAG_EN
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
`endif
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [2:0]            dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY - 1);

  state_t                state_q, state_d;
  elem_t                 elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  phase_q, phase_d;   // 0 = read op, 1 = write op of a two-op element
  logic                  drain_q, drain_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  elem_cfg_t cfg_cur, cfg_enter;
  elem_t     enter_elem;
  logic      enter;
  logic      clear;
  logic      is_write;
  logic      last_op;
  logic      last_addr;
  logic      rd_issue;
  logic      cfg_unused;

  assign cfg_cur   = elem_cfg(elem_q);
  assign is_write  = cfg_cur.has_write && (!cfg_cur.has_read || phase_q);
  assign last_op   = !(cfg_cur.has_read && cfg_cur.has_write) || phase_q;
  assign last_addr = cfg_cur.dir_down ? (addr_q == '0) : (addr_q == LAST_ADDR);
  assign cfg_unused = ^{cfg_cur.wr_bg, cfg_enter.has_read, cfg_enter.has_write, cfg_enter.rd_bg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
      drain_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      drain_q <= drain_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    addr_d     = addr_q;
    phase_d    = phase_q;
    drain_d    = drain_q;
    wdata_d    = wdata_q;
    enter      = 1'b0;
    enter_elem = '0;
    clear      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_SETUP;
          enter      = 1'b1;
          enter_elem = '0;
          clear      = 1'b1;
        end
      end
      ST_SETUP: state_d = ST_RUN;
      ST_RUN: begin
        if (!last_op) begin
          phase_d = 1'b1;
        end else if (!last_addr) begin
          phase_d = 1'b0;
          addr_d  = cfg_cur.dir_down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
        end else if (elem_q == LAST_ELEM) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else begin
          state_d    = ST_SETUP;
          enter      = 1'b1;
          enter_elem = elem_t'(elem_q + 3'd1);
        end
      end
      ST_DRAIN: begin
        if (drain_q) state_d = ST_DONE;
        else         drain_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // wdata is loaded on entry so it is already valid during SETUP, ahead of the element's first write.
    cfg_enter = elem_cfg(enter_elem);
    if (enter) begin
      elem_d  = enter_elem;
      phase_d = 1'b0;
      addr_d  = cfg_enter.dir_down ? LAST_ADDR : '0;
      wdata_d = {DATA_WIDTH{cfg_enter.wr_bg}};
    end
  end

  assign rd_issue       = (state_q == ST_RUN) && !is_write;
  assign mem_write_read = (state_q == ST_RUN) && is_write;
  assign mem_address    = addr_q;
  assign mem_wdata      = wdata_q;
  assign busy           = (state_q == ST_SETUP) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);
  assign pass           = done && (fail_count == '0);
  assign dbg_state      = state_q;

  mbist_cmp_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_cmp (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .issue_valid (rd_issue),
    .issue_bg    (cfg_cur.rd_bg),
`ifdef MBIST_DIAG_EN
    .issue_addr  (addr_q),
    .fail_addr   (fail_addr),
    .fail_data   (fail_data),
`else
`endif
    .rdata       (mem_rdata),
    .fail_count  (fail_count)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: behavioural fault-injecting memories, an abstract
// March C- reference model, and a write scoreboard.
module tb_mbist_march_ctrl;

  localparam int CAP = 16;
  localparam int BUSY_LEN = 10 * CAP + 8;

  logic clk;
  logic rst_n;
  logic start;

  // instance 0: CNT_WIDTH=8; instance 1: CNT_WIDTH=1 with a fixed stuck-at-0 word at address 2
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [7:0] fc0;
  logic [0:0] fc1;
  logic       mem_wr [2];
  logic [3:0] mem_addr [2];
  logic [7:0] mem_wd [2];
  logic [7:0] rd1 [2];
  logic [7:0] rd2 [2];
  logic [7:0] wd_prev [2];
  logic [7:0] mem [2][CAP];
  logic [7:0] sa0 [2][CAP];
  logic [7:0] sa1 [2][CAP];
  logic [2:0] dbg0, dbg1;
`ifdef MBIST_DIAG_EN
  logic [3:0] fa0, fa1;
  logic [7:0] fd0, fd1;
`endif

  logic [11:0] obs_q[$];
  logic [11:0] exp_q[$];

  int total = 0;
  int bad   = 0;

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(CAP), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .done(done0), .pass(pass0),
    .fail_count(fc0),
`ifdef MBIST_DIAG_EN
    .fail_addr(fa0), .fail_data(fd0),
`endif
    .mem_write_read(mem_wr[0]), .mem_address(mem_addr[0]), .mem_wdata(mem_wd[0]),
    .mem_rdata(rd2[0]), .dbg_state(dbg0)
  );

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(CAP), .CNT_WIDTH(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1),
`ifdef MBIST_DIAG_EN
    .fail_addr(fa1), .fail_data(fd1),
`endif
    .mem_write_read(mem_wr[1]), .mem_address(mem_addr[1]), .mem_wdata(mem_wd[1]),
    .mem_rdata(rd2[1]), .dbg_state(dbg1)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural memories: write lands the previous cycle's wdata, reads return after 2 cycles
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_wr[i]) mem[i][mem_addr[i]] <= wd_prev[i];
      rd1[i]     <= (mem[i][mem_addr[i]] | sa1[i][mem_addr[i]]) & ~sa0[i][mem_addr[i]];
      rd2[i]     <= rd1[i];
      wd_prev[i] <= mem_wd[i];
    end
    if (mem_wr[0]) obs_q.push_back({mem_addr[0], wd_prev[0]});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk March C- over an abstract word array, applying stuck bits on read.
  task automatic model_run(input int inst, input bit build_writes,
                           output int fails, output int faddr, output int fsyn);
    int         rd_bg [6] = '{-1, 0, 1, 0, 1, 0};
    int         wr_bg [6] = '{ 0, 1, 0, 1, 0, -1};
    logic [7:0] m [CAP];
    logic [7:0] v, w;
    int         a;
    fails = 0; faddr = 0; fsyn = 0;
    for (int k = 0; k < CAP; k++) m[k] = 8'h00;
    if (build_writes) exp_q.delete();
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < CAP; k++) begin
        a = (e == 3 || e == 4) ? CAP - 1 - k : k;
        if (rd_bg[e] >= 0) begin
          v = (m[a] | sa1[inst][a]) & ~sa0[inst][a];
          w = (rd_bg[e] == 1) ? 8'hFF : 8'h00;
          if (v !== w) begin
            if (fails == 0) begin faddr = a; fsyn = int'(v ^ w); end
            fails++;
          end
        end
        if (wr_bg[e] >= 0) begin
          m[a] = (wr_bg[e] == 1) ? 8'hFF : 8'h00;
          if (build_writes) exp_q.push_back({4'(a), m[a]});
        end
      end
    end
  endtask

  // driver: pulse start, count busy cycles; optional mid-run start pulse or reset abort
  task automatic run_once(input bit pulse_mid, input int abort_at, output int cyc);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (busy0 && cyc < 1000) begin
      cyc++;
      start = (pulse_mid && cyc == 40);
      if (abort_at != 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic clear_faults(input int inst);
    for (int k = 0; k < CAP; k++) begin
      sa0[inst][k] = 8'h00;
      sa1[inst][k] = 8'h00;
    end
  endtask

  task automatic check_run(input string tag, input int cyc, input int base);
    int f0, a0, s0, f1, a1, s1;
    model_run(0, 1'b0, f0, a0, s0);
    model_run(1, 1'b0, f1, a1, s1);
    check({tag, ":busy_len"}, cyc, BUSY_LEN);
    check({tag, ":done"}, done0, 1);
    check({tag, ":pass"}, pass0, (f0 == 0));
    check({tag, ":fail_count"}, fc0, (f0 > 255) ? 255 : f0);
    check({tag, ":sat_count"}, fc1, (f1 > 1) ? 1 : f1);
    check({tag, ":sat_pass"}, pass1, (f1 == 0));
`ifdef MBIST_DIAG_EN
    check({tag, ":fail_addr"}, fa0, (f0 == 0) ? 0 : a0);
    check({tag, ":fail_data"}, fd0, (f0 == 0) ? 0 : s0);
`endif
    check({tag, ":write_count"}, obs_q.size() - base, exp_q.size());
    for (int k = 0; k < exp_q.size() && base + k < obs_q.size(); k++)
      check({tag, ":write"}, obs_q[base + k], exp_q[k]);
  endtask

  initial begin
    int cyc, base, f, a, s;
    rst_n = 1'b0;
    start = 1'b0;
    clear_faults(0);
    clear_faults(1);
    sa0[1][2] = 8'hFF;
    model_run(0, 1'b1, f, a, s);   // builds the expected write sequence

    repeat (3) @(negedge clk);
    check("rst:busy", busy0, 0);
    check("rst:done", done0, 0);
    check("rst:pass", pass0, 0);
    check("rst:fail_count", fc0, 0);
    check("rst:write_read", mem_wr[0], 0);
    check("rst:address", mem_addr[0], 0);
    check("rst:wdata", mem_wd[0], 0);
`ifdef MBIST_DIAG_EN
    check("rst:fail_addr", fa0, 0);
    check("rst:fail_data", fd0, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // fault-free run
    base = obs_q.size();
    run_once(1'b0, 0, cyc);
    check_run("clean", cyc, base);
    repeat (3) @(negedge clk);
    check("clean:done_held", done0, 1);

    // bit 3 stuck-at-1 at address 5
    sa1[0][5] = 8'h08;
    base = obs_q.size();
    run_once(1'b0, 0, cyc);
    check_run("sa1_bit3", cyc, base);
    check("sa1_bit3:count_const", fc0, 3);
`ifdef MBIST_DIAG_EN
    check("sa1_bit3:addr_const", fa0, 5);
    check("sa1_bit3:data_const", fd0, 8'h08);
`endif
    clear_faults(0);

    // start pulsed mid-run is ignored
    base = obs_q.size();
    run_once(1'b1, 0, cyc);
    check_run("mid_start", cyc, base);

    // randomized stuck-at faults
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 1 + r % 2; n++) begin
        int ad, bt;
        ad = $urandom_range(0, CAP - 1);
        bt = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) sa1[0][ad] = sa1[0][ad] | (8'h01 << bt);
        else                           sa0[0][ad] = sa0[0][ad] | (8'h01 << bt);
      end
      base = obs_q.size();
      run_once(1'b0, 0, cyc);
      check_run($sformatf("rand%0d", r), cyc, base);
      clear_faults(0);
    end

    // reset in the middle of E3 (E3 occupies busy cycles 84..116)
    run_once(1'b0, 100, cyc);
    #1;
    check("abort:busy", busy0, 0);
    check("abort:done", done0, 0);
    check("abort:pass", pass0, 0);
    check("abort:fail_count", fc0, 0);
    check("abort:write_read", mem_wr[0], 0);
    check("abort:address", mem_addr[0], 0);
    check("abort:wdata", mem_wd[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort:idle_busy", busy0, 0);
    base = obs_q.size();
    run_once(1'b0, 0, cyc);
    check_run("after_abort", cyc, base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
